// File: rtl/dbus_sram.sv
// Single-port word SRAM behind a valid/rdy data bus with a fixed, parameterised response latency.
// Byte-masked writes and reads share one synchronous array access per request.
module dbus_sram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbus__valid,
    input  logic [31:0] dbus__addr,
    input  logic [3:0]  dbus__wmask,
    input  logic [31:0] dbus__wdata,
    output logic        dbus__rdy,
    output logic [31:0] dbus__rdata
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q;
    logic [3:0]        wmask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              cap;
    logic              acc;
    logic              acc_en;
    logic [IdxW-1:0]   acc_idx;
    logic [3:0]        acc_wmask;
    logic [31:0]       acc_wdata;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              unused_addr;
    assign unused_addr = ^{dbus__addr[31:IdxW+2], dbus__addr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap       = 1'b0;
        acc       = 1'b0;
        acc_idx   = idx_q;
        acc_wmask = wmask_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (dbus__valid) begin
                    cap   = 1'b1;
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: the array access happens on the capture edge itself.
                        state_d   = StAck;
                        acc       = 1'b1;
                        acc_idx   = dbus__addr[IdxW+1:2];
                        acc_wmask = dbus__wmask;
                        acc_wdata = dbus__wdata;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StAck;
                    acc     = 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A reset held across the ACK-entry edge abandons the access, including its write.
    assign acc_en = acc & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wmask_q <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                idx_q   <= dbus__addr[IdxW+1:2];
                wmask_q <= dbus__wmask;
                wdata_q <= dbus__wdata;
            end
        end
    end

    // Not reset: the array and its read register keep their contents across reset.
    always_ff @(posedge clk) begin
        if (acc_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[acc_idx];
        end
    end

    assign dbus__rdy   = (state_q == StAck);
    assign dbus__rdata = (state_q == StAck && wmask_q == 4'd0) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dbus_sram.sv
// Bench for dbus_sram: three instances (1, 0 and 3 wait states) driven with directed and random
// accesses, checked against a byte-level memory model and a continuous protocol monitor.
module tb_dbus_sram;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        valid [3];
    logic [31:0] addr  [3];
    logic [3:0]  wmask [3];
    logic [31:0] wdata [3];
    logic        rdy   [3];
    logic [31:0] rdata [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dbus_sram #(
            .DEPTH_WORDS(1024),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .INIT_FILE  ("")
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .dbus__valid(valid[g]),
            .dbus__addr (addr[g]),
            .dbus__wmask(wmask[g]),
            .dbus__wdata(wdata[g]),
            .dbus__rdy  (rdy[g]),
            .dbus__rdata(rdata[g])
        );
    end

    int          n_pass  = 0;
    int          n_total = 0;
    bit          pend [3];
    logic [31:0] model [3][1024];
    logic [3:0]  known [3][1024];

    function automatic int ws_of(int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] bytes_of(logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_write(int d, logic [31:0] a, logic [3:0] m, logic [31:0] w);
        int idx;
        idx = int'(a[11:2]);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) model[d][idx][8*i +: 8] = w[8*i +: 8];
        end
        known[d][idx] = known[d][idx] | m;
    endtask

    // One complete access on instance d; returns the rdata seen in the response cycle.
    task automatic access(input int d, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] w, input string tag, output logic [31:0] got);
        int          lat;
        bit          seen;
        logic [31:0] km;
        @(negedge clk);
        valid[d] = 1'b1; addr[d] = a; wmask[d] = m; wdata[d] = w;
        @(posedge clk);
        #1;
        pend[d] = 1'b1;
        // Inputs after capture must have no effect.
        addr[d] = $urandom; wdata[d] = $urandom; wmask[d] = 4'($urandom);
        lat = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rdy[d]) seen = 1'b1;
            else lat++;
        end
        got = rdata[d];
        valid[d] = 1'b0;
        chk({tag, "_rdy_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(ws_of(d)));
        if (m != 4'd0) begin
            chk({tag, "_wr_rdata"}, got, 32'd0);
            model_write(d, a, m, w);
        end else begin
            km = bytes_of(known[d][int'(a[11:2])]);
            chk({tag, "_rd_data"}, got & km, model[d][int'(a[11:2])] & km);
        end
        @(posedge clk);
        #1;
        pend[d] = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_single"}, 32'(rdy[d]), 32'd0);
    endtask

    task automatic monitor();
        logic prev [3] = '{1'b0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("protocol", {31'b0, rdy[d] ? (pend[d] && !prev[d]) : (rdata[d] == 32'd0)},
                    32'd1);
                prev[d] = rdy[d];
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] vals [3];
        int          lat;
        bit          seen;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; addr[d] = 32'd0; wmask[d] = 4'd0; wdata[d] = 32'd0;
            for (int i = 0; i < 1024; i++) known[d][i] = 4'd0;
        end
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_rdy", 32'(rdy[d]), 32'd0);
            chk("reset_rdata", rdata[d], 32'd0);
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // One wait state: write then read back, byte mask merge, address wrap.
        access(0, 32'h10, 4'hF, 32'hDEADBEEF, "w10", got);
        access(0, 32'h10, 4'h0, 32'h0, "r10", got);
        chk("r10_value", got, 32'hDEADBEEF);
        access(0, 32'h20, 4'hF, 32'h11223344, "w20", got);
        access(0, 32'h20, 4'h2, 32'h0000AA00, "w20_mask", got);
        access(0, 32'h20, 4'h0, 32'h0, "r20", got);
        chk("r20_value", got, 32'h1122AA44);
        access(0, 32'h1000, 4'hF, 32'hCAFEF00D, "w1000", got);
        access(0, 32'h0, 4'h0, 32'h0, "r0_wrap", got);
        chk("r0_wrap_value", got, 32'hCAFEF00D);

        // Reset asserted during ACK of a write: the write already committed, outputs drop at once.
        @(negedge clk);
        valid[0] = 1'b1; addr[0] = 32'h30; wmask[0] = 4'hF; wdata[0] = 32'hA5A5F00F;
        @(posedge clk);
        #1;
        pend[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = rdy[0];
        end
        chk("rst_ack_rdy_seen", 32'(seen), 32'd1);
        #1;
        rst[0] = 1'b1;
        valid[0] = 1'b0;
        #1;
        chk("rst_ack_rdy", 32'(rdy[0]), 32'd0);
        chk("rst_ack_rdata", rdata[0], 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        pend[0] = 1'b0;
        model_write(0, 32'h30, 4'hF, 32'hA5A5F00F);
        access(0, 32'h30, 4'h0, 32'h0, "r30_after_rst", got);
        chk("r30_value", got, 32'hA5A5F00F);

        // Three wait states: reset two cycles after capture abandons the write.
        access(2, 32'h40, 4'hF, 32'h12345678, "w40", got);
        @(negedge clk);
        valid[2] = 1'b1; addr[2] = 32'h40; wmask[2] = 4'hF; wdata[2] = 32'h55555555;
        @(posedge clk);
        #1;
        pend[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b1;
        valid[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_wait_rdy", 32'(rdy[2]), 32'd0);
        end
        rst[2] = 1'b0;
        pend[2] = 1'b0;
        access(2, 32'h40, 4'h0, 32'h0, "r40_after_rst", got);
        chk("r40_value", got, 32'h12345678);

        // Zero wait states, valid held continuously: responses every second cycle.
        for (int k = 0; k < 3; k++) begin
            vals[k] = $urandom;
            access(1, 32'(k * 4), 4'hF, vals[k], "w_b2b", got);
        end
        @(negedge clk);
        pend[1] = 1'b1;
        valid[1] = 1'b1; addr[1] = 32'h0; wmask[1] = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_rdy_hi", 32'(rdy[1]), 32'd1);
            chk("b2b_rdata", rdata[1], vals[k]);
            addr[1] = 32'((k + 1) * 4);
            if (k == 2) valid[1] = 1'b0;
            @(negedge clk);
            chk("b2b_rdy_lo", 32'(rdy[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        pend[1] = 1'b0;

        // Random traffic, including high address bits that must be ignored.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                logic [3:0]  m;
                a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
                m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                access(d, a, m, $urandom, "rand", got);
            end
        end

        lat = 0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
